// File: rtl/quat_uart_tx.sv
// Serialises one FP16 quaternion as a 10-byte 8N1 UART frame:
// 0xA5, w/i/j/k big-endian, then the XOR of the eight payload bytes.
module quat_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_w,
  input  logic [15:0] in_i,
  input  logic [15:0] in_j,
  input  logic [15:0] in_k,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HEADER    = 8'hA5;
  localparam logic [3:0] LAST_BYTE = 4'd9;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic [63:0]      shadow;
  logic [7:0]       csum;
  logic [7:0]       cur_byte;
  logic             accept;
  logic             baud_end;

  function automatic logic [7:0] xor_fold(input logic [63:0] q);
    logic [7:0] acc;
    acc = 8'h00;
    for (int n = 0; n < 8; n++) acc = acc ^ q[8*n +: 8];
    return acc;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [63:0] q,
                                            input logic [7:0] c);
    case (idx)
      4'd1:    return q[63:56];
      4'd2:    return q[55:48];
      4'd3:    return q[47:40];
      4'd4:    return q[39:32];
      4'd5:    return q[31:24];
      4'd6:    return q[23:16];
      4'd7:    return q[15:8];
      4'd8:    return q[7:0];
      4'd9:    return c;
      default: return HEADER;
    endcase
  endfunction

  assign in_ready   = (state_q == IDLE);
  assign busy       = ~in_ready;
  assign tx         = tx_q;
  assign frame_done = done_q;
  assign accept     = in_valid & in_ready;
  assign baud_end   = (baud_q == BAUD_LAST);
  assign cur_byte   = frame_byte(byte_q, shadow, csum);

  // Payload is latched once per frame; the checksum is settled before byte 9 is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow <= {in_w, in_i, in_j, in_k};
      csum   <= xor_fold({in_w, in_i, in_j, in_k});
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (in_valid) begin
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = 3'd0;
          byte_d  = 4'd0;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_d];
          end
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == LAST_BYTE) begin
            state_d = IDLE;
            byte_d  = 4'd0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_q + 4'd1;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 4'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_quat_uart_tx.sv
// Directed bench for quat_uart_tx at 4 clocks per bit: captures tx/handshake per cycle
// and compares against hand-computed frames.
module tb_quat_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME = 100 * CPB;

  logic        clk, rst, in_valid, in_ready, tx, busy, frame_done;
  logic [15:0] in_w, in_i, in_j, in_k;

  quat_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_i(in_i), .in_j(in_j), .in_k(in_k),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w, i, j, k;
    int          mode;
    logic [7:0]  eb [10];
  } vec_t;

  logic tx_s   [0:1023];
  logic done_s [0:1023];
  logic rdy_s  [0:1023];
  logic busy_s [0:1023];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic start_frame(input logic [15:0] w, i, j, k);
    @(negedge clk);
    chk("ready_before_accept", in_ready, 1'b1);
    in_w = w; in_i = i; in_j = j; in_k = k;
    in_valid = 1'b1;
  endtask

  // mode 0: idle inputs, 1: scramble data every cycle, 2: stray in_valid mid-frame,
  // 3: hold in_valid with the next quaternion until it is taken
  task automatic capture(input int n_cyc, input int mode, input logic [63:0] alt);
    for (int n = 0; n < n_cyc; n++) begin
      @(negedge clk);
      tx_s[n] = tx; done_s[n] = frame_done; rdy_s[n] = in_ready; busy_s[n] = busy;
      case (mode)
        1: begin
          in_valid = 1'b0;
          in_w = 16'($urandom); in_i = 16'($urandom);
          in_j = 16'($urandom); in_k = 16'($urandom);
        end
        2: begin
          in_valid = (n == 150);
          {in_w, in_i, in_j, in_k} = alt;
        end
        3: begin
          in_valid = (n < 401);
          {in_w, in_i, in_j, in_k} = alt;
        end
        default: in_valid = 1'b0;
      endcase
    end
  endtask

  task automatic check_frame(input int base, input logic [7:0] eb [10], input string tag);
    int bad, early, rdy_bad, busy_bad;
    logic [7:0] d;
    logic e;
    bad = 0; early = 0; rdy_bad = 0; busy_bad = 0;
    for (int n = 0; n < FRAME; n++) begin
      int b, p;
      b = n / (10 * CPB);
      p = (n % (10 * CPB)) / CPB;
      e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : eb[b][p-1];
      if (tx_s[base+n] !== e) bad++;
      if (done_s[base+n] !== 1'b0) early++;
      if (rdy_s[base+n] !== 1'b0) rdy_bad++;
      if (busy_s[base+n] !== 1'b1) busy_bad++;
    end
    chk({tag, "_wave_err_cycles"}, bad, 0);
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 8; k++) d[k] = tx_s[base + 10*CPB*b + CPB*(k+1) + CPB/2];
      chk($sformatf("%s_byte%0d", tag, b), d, eb[b]);
    end
    chk({tag, "_done_early"}, early, 0);
    chk({tag, "_ready_in_frame"}, rdy_bad, 0);
    chk({tag, "_busy_in_frame"}, busy_bad, 0);
    chk({tag, "_done_at_end"}, done_s[base+FRAME], 1'b1);
    chk({tag, "_tx_idle_at_end"}, tx_s[base+FRAME], 1'b1);
    chk({tag, "_ready_at_end"}, rdy_s[base+FRAME], 1'b1);
    chk({tag, "_busy_at_end"}, busy_s[base+FRAME], 1'b0);
  endtask

  vec_t vecs [4];
  logic [7:0] eb1 [10];
  logic [7:0] eb2 [10];

  initial begin
    vecs[0] = '{16'h3C00, 16'h0000, 16'h0000, 16'h0000, 0,
                '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C}};
    vecs[1] = '{16'h3800, 16'hB800, 16'h3800, 16'hB800, 0,
                '{8'hA5, 8'h38, 8'h00, 8'hB8, 8'h00, 8'h38, 8'h00, 8'hB8, 8'h00, 8'h00}};
    vecs[2] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 2,
                '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00}};
    vecs[3] = '{16'hFC00, 16'h7E00, 16'h0001, 16'h8000, 1,
                '{8'hA5, 8'hFC, 8'h00, 8'h7E, 8'h00, 8'h00, 8'h01, 8'h80, 8'h00, 8'h03}};

    rst = 1'b1; in_valid = 1'b0;
    in_w = 16'h0; in_i = 16'h0; in_j = 16'h0; in_k = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", frame_done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      start_frame(vecs[v].w, vecs[v].i, vecs[v].j, vecs[v].k);
      capture((vecs[v].mode == 2) ? FRAME + 21 : FRAME + 1, vecs[v].mode,
              64'hCAFE_BABE_0BAD_F00D);
      check_frame(0, vecs[v].eb, $sformatf("vec%0d", v));
      if (vecs[v].mode == 2) begin
        int stray;
        stray = 0;
        for (int n = FRAME + 1; n < FRAME + 21; n++)
          if (tx_s[n] !== 1'b1 || done_s[n] !== 1'b0 || rdy_s[n] !== 1'b1) stray++;
        chk("busy_ignore_no_second_frame", stray, 0);
      end
      repeat (3) @(negedge clk);
    end

    // Back-to-back: in_valid held, second frame taken in the frame_done cycle.
    eb1 = '{8'hA5, 8'h42, 8'h48, 8'h00, 8'h00, 8'h3C, 8'h00, 8'hBC, 8'h00, 8'h8A};
    eb2 = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
    start_frame(16'h4248, 16'h0000, 16'h3C00, 16'hBC00);
    capture(2 * FRAME + 20, 3, 64'h0102_0408_1020_4080);
    check_frame(0, eb1, "b2b_first");
    check_frame(FRAME + 1, eb2, "b2b_second");
    begin
      int pulses;
      pulses = 0;
      for (int n = 0; n < 2 * FRAME + 20; n++) if (done_s[n] === 1'b1) pulses++;
      chk("b2b_done_pulses", pulses, 2);
    end
    repeat (3) @(negedge clk);

    // Reset during byte 4, data bit 3 (that bit is 0, so tx must jump high).
    start_frame(16'h1111, 16'h5600, 16'h2222, 16'h3333);
    capture(178, 0, 64'h0);
    chk("pre_reset_tx_low", tx_s[177], 1'b0);
    chk("pre_reset_busy", busy_s[177], 1'b1);
    rst = 1'b1;
    #1;
    chk("async_reset_tx", tx, 1'b1);
    chk("async_reset_ready", in_ready, 1'b1);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_done", frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_line_idle", tx, 1'b1);
    eb1 = '{8'hA5, 8'h7B, 8'hFF, 8'h04, 8'h00, 8'h35, 8'h55, 8'hC0, 8'h00, 8'h20};
    start_frame(16'h7BFF, 16'h0400, 16'h3555, 16'hC000);
    capture(FRAME + 1, 0, 64'h0);
    check_frame(0, eb1, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
